// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults and state encoding for the Sobel window generator
package sobel_pkg;

    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;
    localparam int DEF_DW    = 8;
    localparam int DEF_CW    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sobel_window_gen_line_delay.sv
// rtl/sobel_window_gen_line_delay.sv - enable-gated shift-register line delay
module line_delay #(
    parameter int DEPTH = 256,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] tap
);

    logic [DW-1:0] sr [DEPTH];

    // Shift one place per enable; the tail is the value pushed DEPTH enables ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign tap = sr[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 window builder for the Sobel core from a raster pixel stream
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sof_i,
    input  logic          pixel_en_i,
    input  logic [DW-1:0] pixel_i,
    output logic [DW-1:0] data_0_0_o,
    output logic [DW-1:0] data_0_1_o,
    output logic [DW-1:0] data_0_2_o,
    output logic [DW-1:0] data_1_0_o,
    output logic [DW-1:0] data_1_1_o,
    output logic [DW-1:0] data_1_2_o,
    output logic [DW-1:0] data_2_0_o,
    output logic [DW-1:0] data_2_1_o,
    output logic [DW-1:0] data_2_2_o,
    output logic          core_en_o,
    output logic [CW-1:0] cnt_col_o,
    output logic [CW-1:0] cnt_row_o,
    output logic          frame_done_o,
    output logic          busy_o
);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, row_q;
    logic [CW-1:0] beat_col, beat_row;
    logic          accept, last_beat, fill_end, interior;
    logic [DW-1:0] tap0, tap1;
    logic [DW-1:0] win [3][3];

    // A sof beat is always accepted and is pixel (0,0) regardless of the old counters.
    assign accept    = pixel_en_i & (sof_i | (state_q == FILL) | (state_q == RUN));
    assign beat_col  = sof_i ? '0 : col_q;
    assign beat_row  = sof_i ? '0 : row_q;
    assign last_beat = (beat_col == CW'(IMG_W-1)) && (beat_row == CW'(IMG_H-1));
    assign fill_end  = (beat_col == CW'(IMG_W-1)) && (beat_row == CW'(1));
    assign interior  = (beat_row >= CW'(2)) && (beat_col >= CW'(2));

    line_delay #(.DEPTH(IMG_W), .DW(DW)) u_ld0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (pixel_i),
        .tap   (tap0)
    );

    line_delay #(.DEPTH(IMG_W), .DW(DW)) u_ld1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (tap0),
        .tap   (tap1)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: sof restarts a frame from any state, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (last_beat)                        state_d = DONE;
            else if (sof_i)                       state_d = FILL;
            else if (state_q == FILL && fill_end) state_d = RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (last_beat) begin
                col_q <= '0;
                row_q <= '0;
            end else if (beat_col == CW'(IMG_W-1)) begin
                col_q <= '0;
                row_q <= beat_row + CW'(1);
            end else begin
                col_q <= beat_col + CW'(1);
                row_q <= beat_row;
            end
        end
    end

    // Window shifts left on each accepted pixel; newest column comes from the line taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= tap1;
            win[1][2] <= tap0;
            win[2][2] <= pixel_i;
        end
    end

    // Window-valid pulse with the centre coordinate, held between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_en_o <= 1'b0;
            cnt_col_o <= '0;
            cnt_row_o <= '0;
        end else begin
            core_en_o <= accept & interior;
            if (accept & interior) begin
                cnt_col_o <= beat_col - CW'(1);
                cnt_row_o <= beat_row - CW'(1);
            end
        end
    end

    assign frame_done_o = (state_q == DONE);
    assign busy_o       = (state_q == FILL) || (state_q == RUN);

    assign data_0_0_o = win[0][0];
    assign data_0_1_o = win[0][1];
    assign data_0_2_o = win[0][2];
    assign data_1_0_o = win[1][0];
    assign data_1_1_o = win[1][1];
    assign data_1_2_o = win[1][2];
    assign data_2_0_o = win[2][0];
    assign data_2_1_o = win[2][1];
    assign data_2_2_o = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen
module tb_sobel_window_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof_i = 1'b0;
    logic          pixel_en_i = 1'b0;
    logic [DW-1:0] pixel_i = '0;
    logic [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic          core_en_o, frame_done_o, busy_o;
    logic [CW-1:0] cnt_col_o, cnt_row_o;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sof_i        (sof_i),
        .pixel_en_i   (pixel_en_i),
        .pixel_i      (pixel_i),
        .data_0_0_o   (d00),
        .data_0_1_o   (d01),
        .data_0_2_o   (d02),
        .data_1_0_o   (d10),
        .data_1_1_o   (d11),
        .data_1_2_o   (d12),
        .data_2_0_o   (d20),
        .data_2_1_o   (d21),
        .data_2_2_o   (d22),
        .core_en_o    (core_en_o),
        .cnt_col_o    (cnt_col_o),
        .cnt_row_o    (cnt_row_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: frame image as written so far and raster position.
    bit m_active = 0;
    int m_r = 0, m_c = 0;
    int img [H][W];
    int exp_col = 0, exp_row = 0;
    int pulses = 0;
    int dones = 0;
    int cap [64][6];
    int ref_cap [64][6];

    typedef struct {
        int idx;
        int d00, d02, d11, d22, col, row;
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_r = 0;
        m_c = 0;
        exp_col = 0;
        exp_row = 0;
    endtask

    task automatic check_all_zero(input string tag);
        int s;
        s = int'(d00) + int'(d01) + int'(d02) + int'(d10) + int'(d11) + int'(d12)
          + int'(d20) + int'(d21) + int'(d22);
        chk({tag, "_win_sum"}, s, 0);
        chk({tag, "_core_en"}, int'(core_en_o), 0);
        chk({tag, "_cnt"}, int'(cnt_col_o) + int'(cnt_row_o), 0);
        chk({tag, "_done_busy"}, int'(frame_done_o) + int'(busy_o), 0);
    endtask

    // One clock of stimulus followed by a full comparison against the model.
    task automatic step(input bit en, input bit sof, input int pix);
        bit acc, pulse, done;
        logic [DW-1:0] aw [3][3];
        @(negedge clk);
        pixel_en_i = en;
        sof_i      = sof;
        pixel_i    = DW'(pix);
        @(posedge clk);
        #1;
        acc   = en && (sof || m_active);
        pulse = 0;
        done  = 0;
        if (acc) begin
            if (sof) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = pix & 255;
            if (m_r >= 2 && m_c >= 2) begin
                pulse   = 1;
                exp_col = m_c - 1;
                exp_row = m_r - 1;
            end
            done = (m_r == H-1) && (m_c == W-1);
            if (m_c == W-1) begin
                m_c = 0;
                m_r++;
            end else begin
                m_c++;
            end
            m_active = !done;
        end
        chk("core_en", int'(core_en_o), int'(pulse));
        chk("frame_done", int'(frame_done_o), int'(done));
        chk("busy", int'(busy_o), int'(m_active));
        chk("cnt_col", int'(cnt_col_o), exp_col);
        chk("cnt_row", int'(cnt_row_o), exp_row);
        if (done) dones++;
        if (pulse && core_en_o) begin
            aw[0][0] = d00; aw[0][1] = d01; aw[0][2] = d02;
            aw[1][0] = d10; aw[1][1] = d11; aw[1][2] = d12;
            aw[2][0] = d20; aw[2][1] = d21; aw[2][2] = d22;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("win_%0d_%0d", i, j), int'(aw[i][j]),
                        img[exp_row-1+i][exp_col-1+j]);
            if (pulses < 64) begin
                cap[pulses][0] = int'(d00);
                cap[pulses][1] = int'(d02);
                cap[pulses][2] = int'(d11);
                cap[pulses][3] = int'(d22);
                cap[pulses][4] = int'(cnt_col_o);
                cap[pulses][5] = int'(cnt_row_o);
            end
            pulses++;
        end
    endtask

    // Ramp frame (pixel = base + raster index), optionally with random gaps.
    task automatic run_ramp(input bit rnd_en, input int base);
        int k;
        bit en;
        k = 0;
        while (k < W*H) begin
            en = rnd_en ? bit'($urandom % 2) : 1'b1;
            if (en) begin
                step(1'b1, k == 0, base + k);
                k++;
            end else begin
                step(1'b0, 1'b0, int'($urandom % 256));
            end
        end
        step(1'b0, 1'b0, 0);
    endtask

    initial begin
        tbl[0] = '{idx: 0,  d00: 0,  d02: 2,  d11: 9,  d22: 18, col: 1, row: 1};
        tbl[1] = '{idx: 6,  d00: 8,  d02: 10, d11: 17, d22: 26, col: 1, row: 2};
        tbl[2] = '{idx: 23, d00: 29, d02: 31, d11: 38, d22: 47, col: 6, row: 4};

        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous ramp frame.
        pulses = 0;
        dones = 0;
        run_ramp(1'b0, 0);
        chk("ramp_pulses", pulses, 24);
        chk("ramp_dones", dones, 1);
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("tbl%0d_d00", t), cap[tbl[t].idx][0], tbl[t].d00);
            chk($sformatf("tbl%0d_d02", t), cap[tbl[t].idx][1], tbl[t].d02);
            chk($sformatf("tbl%0d_d11", t), cap[tbl[t].idx][2], tbl[t].d11);
            chk($sformatf("tbl%0d_d22", t), cap[tbl[t].idx][3], tbl[t].d22);
            chk($sformatf("tbl%0d_col", t), cap[tbl[t].idx][4], tbl[t].col);
            chk($sformatf("tbl%0d_row", t), cap[tbl[t].idx][5], tbl[t].row);
        end
        for (int p = 0; p < 24; p++)
            for (int f = 0; f < 6; f++) ref_cap[p][f] = cap[p][f];

        // Same ramp with random gaps must produce the same pulse sequence.
        pulses = 0;
        dones = 0;
        run_ramp(1'b1, 0);
        chk("gap_pulses", pulses, 24);
        chk("gap_dones", dones, 1);
        for (int p = 0; p < 24; p++)
            for (int f = 0; f < 6; f++)
                chk($sformatf("gap_seq_%0d_%0d", p, f), cap[p][f], ref_cap[p][f]);

        // Beats without sof in IDLE are ignored.
        pulses = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, int'($urandom % 256));
        chk("idle_pulses", pulses, 0);

        // Abort frame 1 at row 3 col 5 with a new sof; frame 2 uses fresh data.
        dones = 0;
        for (int k = 0; k < 3*W + 5; k++) step(1'b1, k == 0, int'($urandom % 256));
        pulses = 0;
        for (int k = 0; k < W*H; k++) step(1'b1, k == 0, (k * 7 + 100) & 255);
        step(1'b0, 1'b0, 0);
        chk("abort_dones", dones, 1);
        chk("abort_pulses", pulses, 24);
        chk("abort_first_col", cap[0][4], 1);
        chk("abort_first_row", cap[0][5], 1);
        chk("abort_first_d00", cap[0][0], 100);

        // Reset mid-frame, then beats without sof produce nothing.
        for (int k = 0; k < 2*W + 4; k++) step(1'b1, k == 0, int'($urandom % 256));
        rst_n = 1'b0;
        pixel_en_i = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, int'($urandom % 256));
        chk("post_rst_pulses", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Builds the 3x3 neighbourhood window that feeds the Sobel core, from a raster-order 8-bit pixel stream. It keeps two line delays and a 3x3 register window. Each time a full interior window is formed, it emits all nine pixels with a one-cycle enable and the centre pixel's column and row counts. It sits between the image source/memory reader and core_module, and drives that core's data_r_c_i, core_en_i, cnt_col_i and cnt_row_i.

Parameters:
IMG_W, 256, pixels per line (3..1023)
IMG_H, 256, lines per frame (3..1023)
DW, 8, pixel width
CW, 10, coordinate counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sof_i  in  1  start of frame; qualifies the pixel_en_i beat it accompanies
pixel_en_i  in  1  pixel_i valid this cycle (accept beat)
pixel_i  in  DW  input pixel, raster order
data_0_0_o .. data_2_2_o  out  DW each (9 ports)  window; r=0 oldest line (row-2), r=2 current line; c=0 col-2, c=2 newest column
core_en_o  out  1  window valid, one-cycle pulse
cnt_col_o  out  CW  centre column of window (col-1)
cnt_row_o  out  CW  centre row of window (row-1)
frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted
busy_o  out  1  high while in FILL or RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: all window regs, all outputs and both counters are 0; state is IDLE.
- States: IDLE, FILL, RUN, DONE.
  - IDLE -> FILL on pixel_en_i & sof_i. That beat is pixel (0,0).
  - FILL -> RUN on the accept beat at col = IMG_W-1, row = 1.
  - RUN -> DONE on the accept beat at (IMG_H-1, IMG_W-1).
  - DONE -> IDLE unconditionally after one cycle. frame_done_o = 1 during DONE.
  - In IDLE, pixel_en_i without sof_i is ignored: no counter, line-delay or window change.
- Accept beat (pixel_en_i=1 in FILL/RUN, or the sof beat):
  - Shift each window row left one column.
  - Load the column-2 entries:
    - data_2_2 <= pixel_i
    - data_1_2 <= line-delay-0 tap (same column, row-1)
    - data_0_2 <= line-delay-1 tap (same column, row-2)
  - Push pixel_i into delay 0 and the delay-0 tap into delay 1.
  - Advance col. At IMG_W-1, col wraps to 0 and row increments.
- Gaps: with pixel_en_i=0, window, delays and counters hold.
- Output timing:
  - core_en_o = 1 in the cycle after an accept beat at row>=2 && col>=2 (latency 1). It is 0 otherwise.
  - cnt_col_o/cnt_row_o are registered alongside and equal col-1/row-1 of that beat. They hold their value between pulses.
  - Window ports change only on accept beats.
- Columns 0..1 of each line never assert core_en_o, even though the window still holds data from the previous line. Borders are not produced: (IMG_W-2)*(IMG_H-2) pulses per frame.
- sof_i on an accept beat in FILL/RUN/DONE aborts the current frame:
  - counters restart at (0,0) with this pixel; state goes to FILL.
  - no frame_done_o pulse for the aborted frame.
  - line-delay contents are not cleared, because they are overwritten before use.
- Reset mid-frame: immediate return to reset values. Any partial window is discarded.
- Widths: all pixel paths are DW unsigned with no arithmetic. Counters are CW bits and compare against IMG_W-1/IMG_H-1.

Decomposition:
- Shared package sobel_pkg holds DW, CW, IMG_W, IMG_H defaults and the state encoding (IDLE=2'd0, FILL=2'd1, RUN=2'd2, DONE=2'd3).
- Sub-module line_delay (params DEPTH=IMG_W, DW) is instantiated twice.
  - Shift-register delay line.
  - Shifts on en; combinational tap = the value pushed DEPTH enables ago.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs are 0 asynchronously; after release, no core_en_o until a new sof_i.
- Ramp frame, IMG_W=8, IMG_H=6, pixel=row*8+col, continuous pixel_en_i.
  - First core_en_o comes one cycle after accepting (2,2): data_0_0=0, data_0_2=2, data_1_1=9, data_2_2=18, cnt_col_o=1, cnt_row_o=1.
  - Exactly 24 pulses in total.
  - The last pulse has cnt_col_o=6, cnt_row_o=4, data_2_2=47.
  - frame_done_o fires the cycle after accepting pixel 47.
- Same ramp with pixel_en_i toggled randomly (about 50% duty) -> identical output sequence of window and count values, with each pulse one cycle after its beat.
- pixel_en_i without sof_i while IDLE, 20 beats -> no pulses; busy_o stays 0.
- sof_i reasserted at (3,5) of frame 1 -> no frame_done_o for frame 1; the next pulse is at cnt=(1,1) of the new frame, using the new data only.
- Streaming into core_module: a vertical edge with left columns 0 and right columns 255 -> core outputs 255 at centre columns adjacent to the edge and 0 elsewhere.
